// File: rtl/fifo_ram.sv
// Simple dual-port RAM: one write port, one synchronous registered read port.
// The read register resets to zero and holds its value when no read is issued.
module fifo_ram #(
  parameter int W  = 16,
  parameter int AW = 4
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [W-1:0]  o_rd_data
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rd_data;

  // Storage has no reset so the array maps onto block or distributed RAM.
  always_ff @(posedge i_clock) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with put/full write side, get/empty read side and registered data.
// Level is its own counter; full/empty decode only the registered level.
module fifo_sync #(
  parameter int W  = 16,
  parameter int AW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic [W-1:0]  in,
  input  logic          put,
  output logic          full,
  output logic [W-1:0]  out,
  input  logic          get,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overrun,
  output logic          underrun
);

  localparam int          DEPTH     = 1 << AW;
  localparam logic [AW:0] LVL_FULL  = DEPTH[AW:0];
  localparam logic [AW:0] LVL_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_level;
  logic          r_overrun;
  logic          r_underrun;

  logic w_full;
  logic w_empty;
  logic w_wr;
  logic w_rd;

  assign w_full  = (r_level == LVL_FULL);
  assign w_empty = (r_level == '0);

  // clear discards any put/get presented with it.
  assign w_wr = put & ~w_full  & ~clear;
  assign w_rd = get & ~w_empty & ~clear;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_level    <= '0;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wp <= r_wp + PTR_ONE;
      end
      if (w_rd) begin
        r_rp <= r_rp + PTR_ONE;
      end
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
      if (put && w_full) begin
        r_overrun <= 1'b1;
      end
      if (get && w_empty) begin
        r_underrun <= 1'b1;
      end
    end
  end

  fifo_ram #(
    .W  (W),
    .AW (AW)
  ) u_ram (
    .i_clock   (clock),
    .i_reset   (reset),
    .i_wr_en   (w_wr),
    .i_wr_addr (r_wp),
    .i_wr_data (in),
    .i_rd_en   (w_rd),
    .i_rd_addr (r_rp),
    .o_rd_data (out)
  );

  assign full     = w_full;
  assign empty    = w_empty;
  assign level    = r_level;
  assign overrun  = r_overrun;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_fifo_sync.sv
// Bench for fifo_sync: vector table, directed corner sequences and a random run
// checked against a queue-based reference model.
module tb_fifo_sync;

  logic        clock;
  logic        reset;
  logic        clear;
  logic [15:0] in_d;
  logic        put;
  logic        full;
  logic [15:0] out;
  logic        get;
  logic        empty;
  logic [4:0]  level;
  logic        overrun;
  logic        underrun;

  fifo_sync #(.W(16), .AW(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .in       (in_d),
    .put      (put),
    .full     (full),
    .out      (out),
    .get      (get),
    .empty    (empty),
    .level    (level),
    .overrun  (overrun),
    .underrun (underrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a plain queue plus the visible registers.
  logic [15:0] q[$];
  logic [15:0] m_out;
  logic        m_ovr;
  logic        m_und;

  typedef struct {
    logic        p;
    logic        g;
    logic        c;
    logic [15:0] d;
    logic [4:0]  lvl;
    logic        emp;
    logic        ful;
    logic [15:0] o;
    logic        ov;
    logic        un;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic p, input logic g, input logic c, input logic [15:0] d);
    bit f;
    bit e;
    if (c) begin
      q.delete();
      m_ovr = 1'b0;
      m_und = 1'b0;
    end else begin
      f = (q.size() == 16);
      e = (q.size() == 0);
      if (p && f) m_ovr = 1'b1;
      if (g && e) m_und = 1'b1;
      if (g && !e) m_out = q.pop_front();
      if (p && !f) q.push_back(d);
    end
  endtask

  task automatic cycle(input logic p, input logic g, input logic c, input logic [15:0] d);
    put  = p;
    get  = g;
    clear = c;
    in_d = d;
    model_step(p, g, c, d);
    @(posedge clock);
    #1;
    put   = 1'b0;
    get   = 1'b0;
    clear = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    put = 1'b0; get = 1'b0; clear = 1'b0; in_d = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    q.delete();
    m_out = '0;
    m_ovr = 1'b0;
    m_und = 1'b0;
  endtask

  function automatic logic [31:0] dut_vec();
    return {7'd0, level, empty, full, out, overrun, underrun};
  endfunction

  task automatic check_model(input string name);
    logic [4:0] ml;
    ml = 5'(q.size());
    check(name, dut_vec(),
          {7'd0, ml, (q.size() == 0), (q.size() == 16), m_out, m_ovr, m_und});
  endtask

  task automatic check_reset_state(input string name);
    check(name, dut_vec(), {7'd0, 5'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0});
  endtask

  initial begin
    // p g c data      lvl emp ful out      ov un
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h1234, 5'd1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 16'h00AA, 5'd1, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 16'h00BB, 5'd2, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 16'h00CC, 5'd3, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 16'h00DD, 5'd0, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 5'd0, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 16'h0055, 5'd1, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 16'h0066, 5'd1, 1'b0, 1'b0, 16'h0055, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 1'b1, 1'b0, 16'h0066, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 16'h0000, 5'd0, 1'b1, 1'b0, 16'h0066, 1'b0, 1'b0};

    do_reset();
    check_reset_state("reset_idle");
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
    check_reset_state("idle_after_reset");

    // Latency, underrun, clear-with-put, put&get on empty.
    for (int i = 0; i < 12; i++) begin
      cycle(vecs[i].p, vecs[i].g, vecs[i].c, vecs[i].d);
      check($sformatf("vec%0d", i), dut_vec(),
            {7'd0, vecs[i].lvl, vecs[i].emp, vecs[i].ful, vecs[i].o, vecs[i].ov, vecs[i].un});
    end

    // Fill and overflow.
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0, 16'(i));
    check("fill_full", {full, level, overrun}, {1'b1, 5'd16, 1'b0});
    cycle(1'b1, 1'b0, 1'b0, 16'hDEAD);
    check("overflow", {full, level, overrun}, {1'b1, 5'd16, 1'b1});
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'h0);
      check($sformatf("drain%0d", i), out, 16'(i));
    end
    check("drain_empty", {empty, level}, {1'b1, 5'd0});

    // Simultaneous put & get at level 5, then while full.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0100 + 16'(i));
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 16'h0105 + 16'(i));
      check($sformatf("pg_lvl5_%0d", i), {level, out}, {5'd5, 16'h0100 + 16'(i)});
    end
    for (int i = 0; i < 11; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0200 + 16'(i));
    check("refill_full", {full, level}, {1'b1, 5'd16});
    cycle(1'b1, 1'b1, 1'b0, 16'hBEEF);
    check("pg_full", {level, overrun, out}, {5'd15, 1'b1, 16'h010A});

    // Reset mid-operation discards everything, including out.
    do_reset();
    check_reset_state("reset_mid_op");

    // Pointer wrap: 40 words, get lagging put by 3 cycles.
    for (int t = 0; t < 43; t++) begin
      cycle(t < 40, t >= 3, 1'b0, 16'h2000 + 16'(t));
      if (t >= 3) check($sformatf("wrap_out%0d", t - 3), out, 16'h2000 + 16'(t - 3));
      check($sformatf("wrap_lvl%0d", t), {31'd0, (level > 5'd4)}, 32'd0);
    end
    check("wrap_end", {empty, level, overrun, underrun}, {1'b1, 5'd0, 1'b0, 1'b0});

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
            1'($urandom_range(0, 63) == 0), 16'($urandom));
      check_model($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
